// File: rtl/ahb_apb_bridge_p.sv
// ahb_apb_bridge_p: parametrised AHB-to-APB3 bridge with windowed slave decode,
// Pready wait states and Pslverr/miss mapping onto a two-cycle AHB ERROR.
// Optional feature: define AHB_APB_POSTED_WRITE_EN to post writes (1-cycle AHB
// data phase, one-entry pending register, sticky Post_err).
module ahb_apb_bridge_p #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       NUM_SLV   = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned       WIN_BITS  = 26
) (
    input  logic               Hclk,
    input  logic               Hresetn,
    input  logic               Hwrite,
    input  logic               Hreadyin,
    input  logic [1:0]         Htrans,
    input  logic [ADDR_W-1:0]  Haddr,
    input  logic [DATA_W-1:0]  Hwdata,
    output logic               Hreadyout,
    output logic [1:0]         Hresp,
    output logic [DATA_W-1:0]  Hrdata,
    output logic [NUM_SLV-1:0] Pselx,
    output logic               Penable,
    output logic               Pwrite,
    output logic [ADDR_W-1:0]  Paddr,
    output logic [DATA_W-1:0]  Pwdata,
    input  logic [DATA_W-1:0]  Prdata,
    input  logic               Pready,
    input  logic               Pslverr,
    output logic               Post_err
);

    localparam int unsigned IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

`ifdef AHB_APB_POSTED_WRITE_EN
    localparam bit PostedEn = 1'b1;
`else
    localparam bit PostedEn = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle, StWlatch, StSetup, StAccess, StErr1, StErr2
    } state_t;

    state_t state_q, state_d;

    // Current APB transfer
    logic [ADDR_W-1:0] paddr_q;
    logic              pwrite_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] pwdata_q;

    // Transfer accepted while a posted write still owns the APB side
    logic              pend_q;
    logic [ADDR_W-1:0] pend_addr_q;
    logic              pend_write_q;
    logic              post_err_q;

    logic [ADDR_W-1:0] src_addr, src_off, src_win;
    logic              src_write, src_hit;
    logic [IDX_W-1:0]  src_idx;
    state_t            src_first;

    logic posted_cur, ready, accept, load, set_pend, set_err;
    logic unused_htrans0;

    assign unused_htrans0 = Htrans[0];
    assign posted_cur     = PostedEn && pwrite_q;
    assign accept         = Hreadyin && Htrans[1] && ready;

    // Decode the next transfer; a held pending transfer always takes priority
    always_comb begin
        src_addr  = pend_q ? pend_addr_q : Haddr;
        src_write = pend_q ? pend_write_q : Hwrite;
        src_off   = src_addr - BASE_ADDR;
        src_win   = src_off >> WIN_BITS;
        src_hit   = (src_addr >= BASE_ADDR) && (src_win < ADDR_W'(NUM_SLV));
        src_idx   = src_win[IDX_W-1:0];
        if (!src_hit) begin
            src_first = StErr1;
        end else if (src_write) begin
            src_first = StWlatch;
        end else begin
            src_first = StSetup;
        end
    end

    // AHB-side ready per state; posted writes free the bus unless a transfer is pending
    always_comb begin
        ready = 1'b1;
        unique case (state_q)
            StIdle:   ready = 1'b1;
            StWlatch: ready = posted_cur;
            StSetup:  ready = posted_cur && !pend_q;
            StAccess: ready = posted_cur ? !pend_q : (Pready && !Pslverr);
            StErr1:   ready = 1'b0;
            StErr2:   ready = 1'b1;
            default:  ready = 1'b1;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        set_pend = 1'b0;
        set_err  = 1'b0;
        unique case (state_q)
            StIdle, StErr2: begin
                if (accept) begin
                    state_d = src_first;
                    load    = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            StWlatch: begin
                state_d  = StSetup;
                set_pend = accept;
            end
            StSetup: begin
                state_d  = StAccess;
                set_pend = accept;
            end
            StAccess: begin
                if (!Pready) begin
                    set_pend = accept;
                end else if (posted_cur) begin
                    // Posted write errors are only recorded, never reported on AHB
                    set_err = Pslverr;
                    if (pend_q || accept) begin
                        state_d = src_first;
                        load    = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (Pslverr) begin
                    state_d = StErr1;
                end else if (accept) begin
                    state_d = src_first;
                    load    = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            StErr1:  state_d = StErr2;
            default: state_d = StIdle;
        endcase
    end

    // State and APB address/direction; a miss leaves the APB side untouched
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q  <= StIdle;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q <= state_d;
            if (load && src_hit) begin
                paddr_q  <= src_addr;
                pwrite_q <= src_write;
                idx_q    <= src_idx;
            end
        end
    end

    // Write data is valid on AHB during WLATCH; capture at its end
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            pwdata_q <= '0;
        end else if (state_q == StWlatch) begin
            pwdata_q <= Hwdata;
        end
    end

    // One-entry pending register, cleared when its transfer is launched
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            pend_q       <= 1'b0;
            pend_addr_q  <= '0;
            pend_write_q <= 1'b0;
        end else if (set_pend) begin
            pend_q       <= 1'b1;
            pend_addr_q  <= Haddr;
            pend_write_q <= Hwrite;
        end else if (load) begin
            pend_q <= 1'b0;
        end
    end

    // Sticky posted-write error flag
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            post_err_q <= 1'b0;
        end else if (set_err) begin
            post_err_q <= 1'b1;
        end
    end

    // Output decode
    always_comb begin
        Hreadyout = ready;
        Hresp     = ((state_q == StErr1) || (state_q == StErr2)) ? 2'b01 : 2'b00;
        Hrdata    = ((state_q == StAccess) && !pwrite_q) ? Prdata : '0;
        Pselx     = ((state_q == StSetup) || (state_q == StAccess)) ?
                    (NUM_SLV'(1) << idx_q) : '0;
        Penable   = (state_q == StAccess);
        Pwrite    = pwrite_q;
        Paddr     = paddr_q;
        Pwdata    = pwdata_q;
        Post_err  = post_err_q;
    end

endmodule

// File: tb/tb_ahb_apb_bridge_p.sv
// tb_ahb_apb_bridge_p: directed vector table plus hand-written multi-cycle sequences
// for ahb_apb_bridge_p (default parameters, 3 slaves).
`timescale 1ns/1ps
module tb_ahb_apb_bridge_p;

    localparam logic [1:0] T = 2'b10;  // NONSEQ
    localparam logic [1:0] I = 2'b00;  // IDLE
    localparam logic [1:0] B = 2'b01;  // BUSY

`ifdef AHB_APB_POSTED_WRITE_EN
    localparam logic PW = 1'b1;
`else
    localparam logic PW = 1'b0;
`endif

    logic        Hclk = 1'b0;
    logic        Hresetn;
    logic        Hwrite;
    logic        Hreadyin;
    logic [1:0]  Htrans;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [31:0] Hrdata;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        Pready;
    logic        Pslverr;
    logic        Post_err;
    logic        hold;

    // Single-slave AHB system: bus ready follows the bridge unless forced low
    assign Hreadyin = Hreadyout & ~hold;

    always #5 Hclk = ~Hclk;

    ahb_apb_bridge_p dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .Hwrite    (Hwrite),
        .Hreadyin  (Hreadyin),
        .Htrans    (Htrans),
        .Haddr     (Haddr),
        .Hwdata    (Hwdata),
        .Hreadyout (Hreadyout),
        .Hresp     (Hresp),
        .Hrdata    (Hrdata),
        .Pselx     (Pselx),
        .Penable   (Penable),
        .Pwrite    (Pwrite),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Prdata    (Prdata),
        .Pready    (Pready),
        .Pslverr   (Pslverr),
        .Post_err  (Post_err)
    );

    typedef struct packed {
        logic [1:0]  trans;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        pready;
        logic        pslverr;
        logic [31:0] prdata;
        logic        hold;
        logic        rdy;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [2:0]  sel;
        logic        en;
        logic        pwr;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic        perr;
    } vec_t;

    vec_t vecs [21];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(
        input logic [1:0] t, input logic w, input logic [31:0] a, input logic [31:0] wd,
        input logic pr, input logic se, input logic [31:0] rd, input logic h,
        input logic r, input logic [1:0] rs, input logic [31:0] rdt, input logic [2:0] s,
        input logic e, input logic pw, input logic [31:0] pa, input logic [31:0] pwd,
        input logic pe);
        vec_t v;
        v.trans = t;   v.write = w;   v.addr = a;    v.wdata = wd;
        v.pready = pr; v.pslverr = se; v.prdata = rd; v.hold = h;
        v.rdy = r;     v.resp = rs;   v.rdata = rdt; v.sel = s;
        v.en = e;      v.pwr = pw;    v.paddr = pa;  v.pwdata = pwd;
        v.perr = pe;
        return v;
    endfunction

    // Apply one cycle's inputs at the falling edge, settle, leave checking to caller
    task automatic drive(input logic [1:0] t, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic pr, input logic se,
                         input logic [31:0] rd, input logic h);
        @(negedge Hclk);
        Htrans = t;  Hwrite = w;   Haddr = a;  Hwdata = wd;
        Pready = pr; Pslverr = se; Prdata = rd; hold = h;
        #1;
    endtask

    task automatic expect_out(input int id, input logic r, input logic [1:0] rs,
                              input logic [31:0] rdt, input logic [2:0] s, input logic e,
                              input logic pw, input logic [31:0] pa, input logic [31:0] pwd,
                              input logic pe);
        logic [104:0] act;
        logic [104:0] exp;
        act = {Hreadyout, Hresp, Hrdata, Pselx, Penable, Pwrite, Paddr, Pwdata, Post_err};
        exp = {r, rs, rdt, s, e, pw, pa, pwd, pe};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL step %0d: got rdy=%b resp=%b rdata=%h sel=%b en=%b pwr=%b paddr=%h pwdata=%h perr=%b; want rdy=%b resp=%b rdata=%h sel=%b en=%b pwr=%b paddr=%h pwdata=%h perr=%b",
                     id, Hreadyout, Hresp, Hrdata, Pselx, Penable, Pwrite, Paddr, Pwdata,
                     Post_err, r, rs, rdt, s, e, pw, pa, pwd, pe);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] ep_addr;
        logic        ep_wr;
        logic        ep_err;

        // Read with two wait states, back-to-back write, two misses,
        // read with Pslverr, pipelined read after ERR2, ignored samples.
        vecs[0]  = mk(T, 0, 32'h8400_0010, 0, 1, 0, 0, 0,
                      1, 2'b00, 0, 3'b000, 0, 0, 0, 0, 0);
        vecs[1]  = mk(I, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0,
                      0, 2'b00, 0, 3'b010, 0, 0, 32'h8400_0010, 0, 0);
        vecs[2]  = mk(I, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0,
                      0, 2'b00, 32'hDEAD_BEEF, 3'b010, 1, 0, 32'h8400_0010, 0, 0);
        vecs[3]  = vecs[2];
        vecs[4]  = mk(T, 1, 32'h8800_0004, 0, 1, 0, 32'hDEAD_BEEF, 0,
                      1, 2'b00, 32'hDEAD_BEEF, 3'b010, 1, 0, 32'h8400_0010, 0, 0);
        vecs[5]  = mk(I, 0, 0, 32'hA5A5_0001, 0, 0, 0, 0,
                      PW, 2'b00, 0, 3'b000, 0, 1, 32'h8800_0004, 0, 0);
        vecs[6]  = mk(I, 0, 0, 0, 0, 0, 0, 0,
                      PW, 2'b00, 0, 3'b100, 0, 1, 32'h8800_0004, 32'hA5A5_0001, 0);
        vecs[7]  = mk(T, 0, 32'h8C00_0000, 0, 1, 0, 0, 0,
                      1, 2'b00, 0, 3'b100, 1, 1, 32'h8800_0004, 32'hA5A5_0001, 0);
        vecs[8]  = mk(I, 0, 0, 0, 0, 0, 0, 0,
                      0, 2'b01, 0, 3'b000, 0, 1, 32'h8800_0004, 32'hA5A5_0001, 0);
        vecs[9]  = mk(T, 0, 32'h7FFF_FFFC, 0, 0, 0, 0, 0,
                      1, 2'b01, 0, 3'b000, 0, 1, 32'h8800_0004, 32'hA5A5_0001, 0);
        vecs[10] = mk(I, 0, 0, 0, 0, 0, 0, 0,
                      0, 2'b01, 0, 3'b000, 0, 1, 32'h8800_0004, 32'hA5A5_0001, 0);
        vecs[11] = mk(T, 0, 32'h8000_0008, 0, 0, 0, 0, 0,
                      1, 2'b01, 0, 3'b000, 0, 1, 32'h8800_0004, 32'hA5A5_0001, 0);
        vecs[12] = mk(I, 0, 0, 0, 0, 0, 0, 0,
                      0, 2'b00, 0, 3'b001, 0, 0, 32'h8000_0008, 32'hA5A5_0001, 0);
        vecs[13] = mk(I, 0, 0, 0, 1, 1, 32'h0000_1234, 0,
                      0, 2'b00, 32'h0000_1234, 3'b001, 1, 0, 32'h8000_0008, 32'hA5A5_0001, 0);
        vecs[14] = mk(I, 0, 0, 0, 0, 0, 0, 0,
                      0, 2'b01, 0, 3'b000, 0, 0, 32'h8000_0008, 32'hA5A5_0001, 0);
        vecs[15] = mk(T, 0, 32'h8000_0000, 0, 0, 0, 0, 0,
                      1, 2'b01, 0, 3'b000, 0, 0, 32'h8000_0008, 32'hA5A5_0001, 0);
        vecs[16] = mk(I, 0, 0, 0, 0, 0, 0, 0,
                      0, 2'b00, 0, 3'b001, 0, 0, 32'h8000_0000, 32'hA5A5_0001, 0);
        vecs[17] = mk(I, 0, 0, 0, 1, 0, 32'hCAFE_F00D, 0,
                      1, 2'b00, 32'hCAFE_F00D, 3'b001, 1, 0, 32'h8000_0000, 32'hA5A5_0001, 0);
        vecs[18] = mk(T, 0, 32'h8400_0000, 0, 0, 0, 0, 1,
                      1, 2'b00, 0, 3'b000, 0, 0, 32'h8000_0000, 32'hA5A5_0001, 0);
        vecs[19] = mk(B, 0, 32'h8400_0000, 0, 0, 0, 0, 0,
                      1, 2'b00, 0, 3'b000, 0, 0, 32'h8000_0000, 32'hA5A5_0001, 0);
        vecs[20] = mk(I, 0, 0, 0, 0, 0, 0, 0,
                      1, 2'b00, 0, 3'b000, 0, 0, 32'h8000_0000, 32'hA5A5_0001, 0);

        Hresetn = 1'b0;
        Htrans = I; Hwrite = 0; Haddr = 0; Hwdata = 0;
        Pready = 0; Pslverr = 0; Prdata = 0; hold = 0;
        #1;
        expect_out(99, 1, 2'b00, 0, 3'b000, 0, 0, 0, 0, 0);
        @(negedge Hclk);
        Hresetn = 1'b1;

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].trans, vecs[i].write, vecs[i].addr, vecs[i].wdata,
                  vecs[i].pready, vecs[i].pslverr, vecs[i].prdata, vecs[i].hold);
            expect_out(i, vecs[i].rdy, vecs[i].resp, vecs[i].rdata, vecs[i].sel,
                       vecs[i].en, vecs[i].pwr, vecs[i].paddr, vecs[i].pwdata, vecs[i].perr);
        end

`ifdef AHB_APB_POSTED_WRITE_EN
        // Posted write to slave 0 with Pslverr, read of slave 1 held pending behind it
        drive(T, 1, 32'h8000_0000, 0, 0, 0, 0, 0);
        expect_out(200, 1, 2'b00, 0, 3'b000, 0, 0, 32'h8000_0000, 32'hA5A5_0001, 0);
        drive(T, 0, 32'h8400_0000, 32'h0000_0011, 0, 0, 0, 0);
        expect_out(201, 1, 2'b00, 0, 3'b000, 0, 1, 32'h8000_0000, 32'hA5A5_0001, 0);
        drive(I, 0, 0, 0, 0, 0, 0, 0);
        expect_out(202, 0, 2'b00, 0, 3'b001, 0, 1, 32'h8000_0000, 32'h0000_0011, 0);
        drive(I, 0, 0, 0, 1, 1, 0, 0);
        expect_out(203, 0, 2'b00, 0, 3'b001, 1, 1, 32'h8000_0000, 32'h0000_0011, 0);
        drive(I, 0, 0, 0, 0, 0, 0, 0);
        expect_out(204, 0, 2'b00, 0, 3'b010, 0, 0, 32'h8400_0000, 32'h0000_0011, 1);
        drive(I, 0, 0, 0, 1, 0, 32'h5A5A_1234, 0);
        expect_out(205, 1, 2'b00, 32'h5A5A_1234, 3'b010, 1, 0, 32'h8400_0000,
                   32'h0000_0011, 1);
        drive(I, 0, 0, 0, 0, 0, 0, 0);
        expect_out(206, 1, 2'b00, 0, 3'b000, 0, 0, 32'h8400_0000, 32'h0000_0011, 1);
        ep_addr = 32'h8400_0000; ep_wr = 1'b0; ep_err = 1'b1;
`else
        // Non-posted write with Pslverr: ERROR after ACCESS, no sticky flag
        drive(T, 1, 32'h8000_0000, 0, 0, 0, 0, 0);
        expect_out(200, 1, 2'b00, 0, 3'b000, 0, 0, 32'h8000_0000, 32'hA5A5_0001, 0);
        drive(I, 0, 0, 32'h0000_0011, 0, 0, 0, 0);
        expect_out(201, 0, 2'b00, 0, 3'b000, 0, 1, 32'h8000_0000, 32'hA5A5_0001, 0);
        drive(I, 0, 0, 0, 0, 0, 0, 0);
        expect_out(202, 0, 2'b00, 0, 3'b001, 0, 1, 32'h8000_0000, 32'h0000_0011, 0);
        drive(I, 0, 0, 0, 1, 1, 0, 0);
        expect_out(203, 0, 2'b00, 0, 3'b001, 1, 1, 32'h8000_0000, 32'h0000_0011, 0);
        drive(I, 0, 0, 0, 0, 0, 0, 0);
        expect_out(204, 0, 2'b01, 0, 3'b000, 0, 1, 32'h8000_0000, 32'h0000_0011, 0);
        drive(I, 0, 0, 0, 0, 0, 0, 0);
        expect_out(205, 1, 2'b01, 0, 3'b000, 0, 1, 32'h8000_0000, 32'h0000_0011, 0);
        drive(I, 0, 0, 0, 0, 0, 0, 0);
        expect_out(206, 1, 2'b00, 0, 3'b000, 0, 1, 32'h8000_0000, 32'h0000_0011, 0);
        ep_addr = 32'h8000_0000; ep_wr = 1'b1; ep_err = 1'b0;
`endif

        // Asynchronous reset while ACCESS is stalled by Pready=0
        drive(T, 0, 32'h8000_0004, 0, 0, 0, 0, 0);
        expect_out(300, 1, 2'b00, 0, 3'b000, 0, ep_wr, ep_addr, 32'h0000_0011, ep_err);
        drive(I, 0, 0, 0, 0, 0, 0, 0);
        expect_out(301, 0, 2'b00, 0, 3'b001, 0, 0, 32'h8000_0004, 32'h0000_0011, ep_err);
        drive(I, 0, 0, 0, 0, 0, 32'h0000_0077, 0);
        expect_out(302, 0, 2'b00, 32'h0000_0077, 3'b001, 1, 0, 32'h8000_0004,
                   32'h0000_0011, ep_err);
        #1;
        Hresetn = 1'b0;
        #1;
        expect_out(303, 1, 2'b00, 0, 3'b000, 0, 0, 0, 0, 0);
        @(negedge Hclk);
        #1;
        expect_out(304, 1, 2'b00, 0, 3'b000, 0, 0, 0, 0, 0);
        Hresetn = 1'b1;
        drive(I, 0, 0, 0, 1, 0, 32'h0000_0077, 0);
        expect_out(305, 1, 2'b00, 0, 3'b000, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_apb_bridge_p.md
# ahb_apb_bridge_p

Parametrised AHB-to-APB3 bridge. It is the next generation of the current bridge top and replaces its fixed 3-slave, 32-bit, no-wait-state datapath. It decodes AHB transfers into a configurable number of APB slave windows and honours APB3 `Pready` wait states. It maps `Pslverr` and undecoded addresses onto a two-cycle AHB ERROR response, and can optionally post writes.

## Interface
- `ADDR_W`, 32: AHB/APB address width.
- `DATA_W`, 32: data width (8, 16 or 32).
- `NUM_SLV`, 3: APB slave count, 1–8.
- `BASE_ADDR`, 32'h8000_0000: start of slave window 0.
- `WIN_BITS`, 26: log2 of window size. Default is 64 MB per slave.
- `Hclk`  in  1  bridge clock.
- `Hresetn`  in  1  asynchronous active-low reset.
- `Hwrite`  in  1  AHB direction. 1 = write.
- `Hreadyin`  in  1  AHB bus ready.
- `Htrans`  in  2  AHB transfer type. NONSEQ = 10, SEQ = 11.
- `Haddr`  in  ADDR_W  AHB address.
- `Hwdata`  in  DATA_W  AHB write data.
- `Hreadyout`  out  1  bridge ready.
- `Hresp`  out  2  00 = OKAY, 01 = ERROR.
- `Hrdata`  out  DATA_W  read data.
- `Pselx`  out  NUM_SLV  one-hot slave select.
- `Penable`  out  1  APB enable.
- `Pwrite`  out  1  APB direction.
- `Paddr`  out  ADDR_W  APB address.
- `Pwdata`  out  DATA_W  APB write data.
- `Prdata`  in  DATA_W  APB read data, from the selected slave.
- `Pready`  in  1  APB3 ready.
- `Pslverr`  in  1  APB3 slave error.
- `Post_err`  out  1  sticky posted-write error flag. Tied 0 when posting is compiled out.

## Operation
- Valid transfer = `Hreadyin` && `Htrans[1]`, sampled at a rising `Hclk` edge. On acceptance, address, direction and decode are registered.
- Decode: `off = Haddr - BASE_ADDR`, `idx = off >> WIN_BITS`.
  - Hit when `Haddr >= BASE_ADDR` and `idx < NUM_SLV`.
  - On a hit, `Pselx[idx]` is driven.
  - On a miss, no APB cycle is issued.
- FSM states:
  - IDLE
  - WLATCH: write data capture.
  - SETUP: `Pselx` on, `Penable=0`.
  - ACCESS: `Pselx` and `Penable` on.
  - ERR1
  - ERR2
- Transitions:
  - IDLE → SETUP on a read hit.
  - IDLE → WLATCH on a write hit. `Hwdata` is captured into `Pwdata` at the end of WLATCH.
  - IDLE → ERR1 on a miss, read or write.
  - WLATCH → SETUP.
  - SETUP → ACCESS.
  - ACCESS holds while `Pready=0`.
  - ACCESS with `Pready=1` → IDLE, or directly to the next transfer's first state if a valid transfer is sampled at that edge.
  - ACCESS with `Pready=1` and `Pslverr=1` → ERR1.
  - ERR1 → ERR2 → IDLE, or next transfer.
- Outputs by state:
  - `Hreadyout=0` in WLATCH, SETUP, ACCESS with `Pready=0`, and ERR1.
  - `Hreadyout=1` in IDLE, ERR2, and ACCESS with `Pready=1 && !Pslverr`.
  - `Hresp=01` in ERR1 and ERR2, otherwise 00.
  - `Hrdata = Prdata` in ACCESS of a read, else 0.
- `Paddr` and `Pwrite` hold their last values after a transfer completes. `Pselx` and `Penable` deassert in IDLE.
- Reset (asynchronous, any state): FSM → IDLE. `Hreadyout=1`, `Hresp=00`, `Hrdata=0`. `Pselx`, `Penable`, `Pwrite`, `Paddr`, `Pwdata` and `Post_err` all = 0. Any APB transfer in flight is abandoned.

## Timing
- Read, no wait states: data phase of 2 cycles (SETUP, ACCESS). Adds 1 cycle per `Pready=0` cycle.
- Write, not posted: data phase of 3 cycles (WLATCH, SETUP, ACCESS).
- Error: 2 cycles (ERR1, ERR2). For a `Pslverr` error, these follow ACCESS.
- Back-to-back: a transfer sampled in the final data-phase cycle starts its SETUP or WLATCH on the next cycle, with no IDLE gap.
- IDLE or BUSY `Htrans`, or `Hreadyin=0`, in any cycle: the sample is ignored and in-flight APB state is unaffected.

## Configuration
- `AHB_APB_POSTED_WRITE_EN` defined:
  - A write hit completes in WLATCH with `Hreadyout=1`, `Hresp=00` (1-cycle data phase). SETUP and ACCESS then run with the AHB side free.
  - A transfer sampled during a posted write's SETUP/ACCESS is held in a one-entry pending register. Its data phase holds `Hreadyout=0` until the posted ACCESS completes, then it proceeds. A pending write's `Hwdata` is captured at that point.
  - `Pslverr` on a posted write sets `Post_err`, which stays set until reset. No AHB error is reported.
  - Misses still return ERROR.
- Undefined: writes are non-posted, as described above. `Post_err` = 0.

## Test plan
- Reset mid-ACCESS with `Pready=0` → next cycle `Pselx=0`, `Penable=0`, `Hreadyout=1`, `Hresp=00`.
- Read at 0x8400_0010, `Prdata`=0xDEAD_BEEF, `Pready` low for 2 cycles → `Pselx`=3'b010, `Paddr`=0x8400_0010. Data phase of 4 cycles. `Hrdata`=0xDEAD_BEEF with `Hreadyout=1`.
- Write 0xA5A5_0001 to 0x8800_0004 → `Pselx`=3'b100, `Pwrite=1`, `Pwdata`=0xA5A5_0001 stable across SETUP/ACCESS. 3-cycle data phase (1 cycle posted).
- Read at 0x8C00_0000 with `NUM_SLV`=3, and at 0x7FFF_FFFC → no `Pselx`. ERR1 gives `Hresp`=01 with `Hreadyout=0`. ERR2 gives `Hresp`=01 with `Hreadyout=1`.
- Read with `Pready`=1, `Pslverr`=1 → two-cycle ERROR after ACCESS. Next pipelined read at 0x8000_0000 then proceeds normally.
- Posted build: write to slave 0 (`Pslverr`=1) immediately followed by a read of slave 1 → write completes in 1 cycle. The read stalls until the write's ACCESS ends, then returns OKAY. `Post_err` rises and stays 1.
